// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request payload for the register-file
// writeback arbiter slice.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_BE_W   = 4;

  // One register-file write: destination, data, byte enables (addr in MSBs).
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
    logic [REG_BE_W-1:0]   be;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO holding long-latency writeback requests.
// The caller guarantees push only when count < DEPTH and pop only when
// not empty; pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  push_data,
  input  logic                     pop,
  output wb_req_t                  pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: the pipeline writeback always wins the
// single write port; long-latency (mul/div) results queue in wb_fifo and
// drain on idle pipeline cycles. Optional busy-register scoreboard is
// enabled by defining REGFILE_WB_SCOREBOARD_EN; otherwise stall is 0.
//
// Handshake: an m write transfers on every cycle where m_wr_valid and
// m_wr_ready are both high; m_wr_ready depends only on registered FIFO
// occupancy (never on m_wr_valid) and is low during reset. The pipeline
// port has no ready: a p write is always taken on the cycle it is valid.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          p_wr_valid,
  input  logic [REG_ADDR_W-1:0]         p_wr_addr,
  input  logic [REG_DATA_W-1:0]         p_wr_data,
  input  logic [REG_BE_W-1:0]           p_wr_be,
  input  logic                          m_wr_valid,
  output logic                          m_wr_ready,
  input  logic [REG_ADDR_W-1:0]         m_wr_addr,
  input  logic [REG_DATA_W-1:0]         m_wr_data,
  input  logic [REG_BE_W-1:0]           m_wr_be,
  input  logic                          iss_valid,
  input  logic [REG_ADDR_W-1:0]         iss_addr,
  input  logic [REG_ADDR_W-1:0]         rs_addr,
  input  logic [REG_ADDR_W-1:0]         rt_addr,
  output logic                          stall,
  output logic [REG_ADDR_W-1:0]         rf_addr,
  output logic [REG_DATA_W-1:0]         rf_data,
  output logic [REG_BE_W-1:0]           rf_be,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  wb_req_t m_req;
  wb_req_t head;
  wb_req_t win;
  logic    win_valid;
  logic    push;
  logic    pop;
  logic    empty;

  assign m_req      = '{addr: m_wr_addr, data: m_wr_data, be: m_wr_be};
  assign m_wr_ready = !rst && (fifo_count < DEPTH_C);
  assign push       = m_wr_valid && m_wr_ready;
  // The FIFO only drains when the pipeline leaves the port idle; no bypass.
  assign pop        = !p_wr_valid && !empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (m_req),
    .pop       (pop),
    .pop_data  (head),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Fixed-priority winner selection: pipeline first, then FIFO head.
  always_comb begin
    win       = head;
    win_valid = pop;
    if (p_wr_valid) begin
      win       = '{addr: p_wr_addr, data: p_wr_data, be: p_wr_be};
      win_valid = 1'b1;
    end
  end

  // Registered write port; writes to r0 occupy the slot but enable no bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_addr <= '0;
      rf_data <= '0;
      rf_be   <= '0;
    end else if (win_valid) begin
      rf_addr <= win.addr;
      rf_data <= win.data;
      rf_be   <= (win.addr == '0) ? '0 : win.be;
    end else begin
      rf_be   <= '0;
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [31:0] pending;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign set_mask = (iss_valid && iss_addr != '0) ? (32'd1 << iss_addr) : 32'd0;
  assign clr_mask = (pop && head.addr != '0) ? (32'd1 << head.addr) : 32'd0;

  // Busy-register tracking; a set on the same edge as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | set_mask;
  end

  assign stall = pending[rs_addr] | pending[rt_addr];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_addr, rs_addr, rt_addr};
  assign stall     = 1'b0;
`endif

endmodule
